// File: rtl/sys_array_pkg.sv
// Shared types and default geometry for the systolic-array feeder.
package sys_array_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ARRAY_H    = 4;
    localparam int unsigned DEF_ARRAY_W    = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/sys_array_skew_line.sv
// Per-row activation delay line: a launch register followed by DEPTH skew stages.
module sys_array_skew_line #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH+1];
    logic [DEPTH:0]        valid_q;

    // Shift data and valid together; synchronous clear drops anything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH];
    assign out_valid = valid_q[DEPTH];

endmodule

// File: rtl/sys_array_feeder.sv
// Feeds a weight-stationary systolic array: loads one weight row per beat,
// then streams input vectors with a per-row diagonal skew and flushes the array.
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ARRAY_H    = DEF_ARRAY_H,
    parameter int unsigned ARRAY_W    = DEF_ARRAY_W,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          num_vec,
    output logic                          busy,
    output logic                          done,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [ARRAY_W*DATA_WIDTH-1:0] w_data,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [ARRAY_H*DATA_WIDTH-1:0] x_data,
    output logic [ARRAY_H-1:0]            weight_load,
    output logic [ARRAY_W*DATA_WIDTH-1:0] weight_data,
    output logic [ARRAY_H*DATA_WIDTH-1:0] act_data,
    output logic [ARRAY_H-1:0]            act_valid
);

    localparam int unsigned WCW       = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1;
    localparam int unsigned FLUSH_LEN = ARRAY_H + ARRAY_W - 1;
    localparam int unsigned FCW       = $clog2(FLUSH_LEN + 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] num_vec_q;
    logic [CNT_WIDTH-1:0] vec_cnt;
    logic [WCW-1:0]       w_cnt;
    logic [FCW-1:0]       f_cnt;
    logic                 w_fire;
    logic                 x_fire;
    logic                 w_last;
    logic                 x_last;
    logic                 f_last;
    logic                 start_job;

    // Ready flags are registered copies of the state, so they double as state decodes.
    assign w_fire    = w_valid & w_ready;
    assign x_fire    = x_valid & x_ready;
    assign w_last    = (w_cnt == WCW'(ARRAY_H - 1));
    assign x_last    = ((vec_cnt + CNT_WIDTH'(1)) == num_vec_q);
    assign f_last    = (f_cnt == FCW'(FLUSH_LEN - 1));
    assign start_job = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_job) state_next = LOAD_W;
            LOAD_W:  if (w_fire && w_last) state_next = (num_vec_q != '0) ? STREAM : FLUSH;
            STREAM:  if (x_fire && x_last) state_next = FLUSH;
            FLUSH:   if (f_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Job length latch plus beat and flush counters; counters hold rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_vec_q <= '0;
            vec_cnt   <= '0;
            w_cnt     <= '0;
            f_cnt     <= '0;
        end else if (start_job) begin
            num_vec_q <= num_vec;
            vec_cnt   <= '0;
            w_cnt     <= '0;
            f_cnt     <= '0;
        end else begin
            if (w_fire && !w_last) w_cnt <= w_cnt + WCW'(1);
            if (x_fire && !x_last) vec_cnt <= vec_cnt + CNT_WIDTH'(1);
            if (state == FLUSH) f_cnt <= f_cnt + FCW'(1);
        end
    end

    // Registered status, handshake and weight outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            w_ready     <= 1'b0;
            x_ready     <= 1'b0;
            weight_load <= '0;
            weight_data <= '0;
        end else begin
            busy        <= (state_next != IDLE);
            done        <= (state_next == DONE);
            w_ready     <= (state_next == LOAD_W);
            x_ready     <= (state_next == STREAM);
            weight_load <= w_fire ? (ARRAY_H'(1) << w_cnt) : '0;
            if (w_fire) weight_data <= w_data;
        end
    end

    // One skew line per row; cycles without a handshake launch a zero bubble.
    for (genvar r = 0; r < ARRAY_H; r++) begin : g_row
        sys_array_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (r)
        ) u_skew_line (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_data   (x_fire ? x_data[r*DATA_WIDTH +: DATA_WIDTH] : '0),
            .in_valid  (x_fire),
            .out_data  (act_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (act_valid[r])
        );
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Scoreboard bench for sys_array_feeder: stimulus pushes expectations, a monitor checks outputs.
module tb_sys_array_feeder;

    localparam int unsigned DW = 8;
    localparam int unsigned AH = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned FLUSH_LEN = AH + AW - 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [CW-1:0]      num_vec = '0;
    logic               busy, done, w_ready, x_ready;
    logic               w_valid = 1'b0;
    logic               x_valid = 1'b0;
    logic [AW*DW-1:0]   w_data = '0;
    logic [AH*DW-1:0]   x_data = '0;
    logic [AH-1:0]      weight_load;
    logic [AW*DW-1:0]   weight_data;
    logic [AH*DW-1:0]   act_data;
    logic [AH-1:0]      act_valid;

    sys_array_feeder #(
        .DATA_WIDTH (DW), .ARRAY_H (AH), .ARRAY_W (AW), .CNT_WIDTH (CW)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start), .num_vec (num_vec),
        .busy (busy), .done (done),
        .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data),
        .x_valid (x_valid), .x_ready (x_ready), .x_data (x_data),
        .weight_load (weight_load), .weight_data (weight_data),
        .act_data (act_data), .act_valid (act_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned      cyc;
        int               row;
        logic [DW-1:0]    data;
    } act_exp_t;

    typedef struct {
        int unsigned      cyc;
        int               k;
        logic [AW*DW-1:0] data;
    } w_exp_t;

    act_exp_t    act_q[$];
    w_exp_t      w_q[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int unsigned done_cyc = 0;
    int          vcount[AH];
    bit          mon_en = 1'b0;
    bit          mon_hold = 1'b0;
    bit          xr_seen = 1'b0;
    int unsigned last_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compare every presented weight load and activation against the scoreboard.
    w_exp_t  we;
    int      found;
    int      qi;
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (x_ready) xr_seen = 1'b1;
            if (!busy) begin
                check("idle_w_ready", 64'(w_ready), 64'd0);
                check("idle_x_ready", 64'(x_ready), 64'd0);
            end
            if (!mon_hold) begin
                if (weight_load != '0) begin
                    check("wl_onehot", 64'($onehot(weight_load)), 64'd1);
                    if (w_q.size() == 0) begin
                        check("wl_unexpected", 64'(weight_load), 64'd0);
                    end else begin
                        we = w_q.pop_front();
                        check("wl_cycle", 64'(cyc), 64'(we.cyc));
                        check("wl_bit", 64'(weight_load), 64'(1) << we.k);
                        check("wl_data", 64'(weight_data), 64'(we.data));
                    end
                end
                if (w_q.size() > 0 && w_q[0].cyc < cyc) begin
                    check("wl_missing", 64'(weight_load), 64'(1) << w_q[0].k);
                    void'(w_q.pop_front());
                end
                for (int r = 0; r < int'(AH); r++) begin
                    if (act_valid[r]) begin
                        vcount[r]++;
                        found = -1;
                        for (int i = 0; i < act_q.size(); i++) begin
                            if (act_q[i].row == r && found < 0) found = i;
                        end
                        if (found < 0) begin
                            check("act_unexpected_valid", 64'(r), 64'hFF);
                        end else begin
                            check("act_cycle", 64'(cyc), 64'(act_q[found].cyc));
                            check("act_data", 64'(act_data[r*DW +: DW]), 64'(act_q[found].data));
                            act_q.delete(found);
                        end
                    end else begin
                        check("act_bubble_zero", 64'(act_data[r*DW +: DW]), 64'd0);
                    end
                end
                qi = 0;
                while (qi < act_q.size()) begin
                    if (act_q[qi].cyc < cyc) begin
                        check("act_missing_row", 64'(act_q[qi].row), 64'hFF);
                        act_q.delete(qi);
                    end else begin
                        qi++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present ARRAY_H weight beats, optionally with random stalls.
    task automatic load_weights(input bit directed);
        int k = 0;
        int guard = 0;
        while (k < int'(AH) && guard < 200) begin
            w_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            w_data  = directed ? (32'h04030201 + 32'(k)) : 32'($urandom);
            @(negedge clk);
            if (w_valid && w_ready) begin
                w_q.push_back('{cyc + 1, k, w_data});
                last_hs = cyc;
                k++;
            end
            tick();
            guard++;
        end
        w_valid = 1'b0;
        if (guard >= 200) check("w_timeout", 64'(k), 64'(AH));
        check("w_ready_after_load", 64'(w_ready), 64'd0);
    endtask

    // mode 0: random gaps, 1: two idle cycles between beats, 2: fixed skew pattern.
    task automatic stream(input int nv, input int mode, input bit glitch, input int stop_after);
        int acc = 0;
        int guard = 0;
        int gap = 0;
        bit glitched = 1'b0;
        while (acc < nv && acc < stop_after && guard < 2000) begin
            case (mode)
                1: begin
                    x_valid = (gap == 0);
                    if (gap > 0) gap--;
                end
                2: x_valid = 1'b1;
                default: x_valid = ($urandom_range(0, 2) != 0);
            endcase
            x_data = (mode == 2) ? 32'h04FD02FF : 32'($urandom);
            if (glitch && acc == 1 && !glitched) begin
                start    = 1'b1;
                num_vec  = 16'd1;
                glitched = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (x_valid && x_ready) begin
                for (int r = 0; r < int'(AH); r++) begin
                    act_q.push_back('{cyc + 1 + r, r, x_data[r*DW +: DW]});
                end
                last_hs = cyc;
                acc++;
                gap = 2;
            end
            tick();
            guard++;
        end
        x_valid = 1'b0;
        start   = 1'b0;
        if (guard >= 2000) check("x_timeout", 64'(acc), 64'(nv));
    endtask

    task automatic begin_job(input int nv);
        xr_seen = 1'b0;
        for (int r = 0; r < int'(AH); r++) vcount[r] = 0;
        start   = 1'b1;
        num_vec = CW'(nv);
        tick();
        start   = 1'b0;
        num_vec = CW'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        check("w_ready_after_start", 64'(w_ready), 64'd1);
    endtask

    task automatic run_job(input int nv, input bit wdir, input int mode, input bit glitch);
        int d0 = done_cnt;
        int guard = 0;
        int unsigned exp_done;
        begin_job(nv);
        load_weights(wdir);
        if (nv > 0) stream(nv, mode, glitch, nv);
        exp_done = last_hs + FLUSH_LEN + 1;
        while (done_cnt == d0 && guard < 100) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
        check("busy_after_done", 64'(busy), 64'd0);
        check("act_q_drained", 64'(act_q.size()), 64'd0);
        for (int r = 0; r < int'(AH); r++) check("valids_per_row", 64'(vcount[r]), 64'(nv));
        if (nv == 0) check("x_ready_never", 64'(xr_seen), 64'd0);
    endtask

    task automatic reset_mid_stream();
        int d0;
        begin_job(8);
        load_weights(1'b0);
        stream(8, 0, 1'b0, 2);
        reset_n  = 1'b0;
        x_valid  = 1'b0;
        mon_hold = 1'b1;
        tick();
        reset_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_act_valid", 64'(act_valid), 64'd0);
        check("rst_act_data", 64'(act_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        act_q.delete();
        w_q.delete();
        d0 = done_cnt;
        #4;
        mon_hold = 1'b0;
        repeat (15) tick();
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_w_ready", 64'(w_ready), 64'd0);
        check("reset_x_ready", 64'(x_ready), 64'd0);
        check("reset_weight_load", 64'(weight_load), 64'd0);
        check("reset_weight_data", 64'(weight_data), 64'd0);
        check("reset_act_data", 64'(act_data), 64'd0);
        check("reset_act_valid", 64'(act_valid), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        run_job(1, 1'b1, 2, 1'b0);
        run_job(3, 1'b0, 1, 1'b0);
        run_job(0, 1'b1, 0, 1'b0);
        run_job(5, 1'b0, 0, 1'b1);
        for (int j = 0; j < 5; j++) run_job(int'($urandom_range(1, 10)), 1'b0, 0, 1'b0);
        reset_mid_stream();
        run_job(2, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
